ws_frame_sequencer: RTL and testbench

- Controller that sequences the pulse-width timer for the single-wire LED input.
- Tracks line state from edge strobes and classifies each high pulse as bit 0, bit 1 or glitch using the timer's elapsed-cycle value.
- Assembles 24-bit pixel words MSB first and detects the low reset gap that latches a frame.
- Sits between the edge detector/timer and the pixel buffer; hands pixels downstream over a valid/ready interface.

---
 rtl/ws_frame_sequencer_if.sv | 23 ++
 rtl/ws_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ws_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ws_frame_sequencer_if.sv
// Pixel hand-off bundle between the frame sequencer (master) and the pixel buffer (slave).
interface ws_frame_sequencer_if #(
  parameter int IDX_W = 9
);
  logic [23:0]      o_pixel_data;
  logic             o_pixel_valid;
  logic             i_pixel_ready;
  logic [IDX_W-1:0] o_pixel_index;

  modport master (
    output o_pixel_data,
    output o_pixel_valid,
    output o_pixel_index,
    input  i_pixel_ready
  );

  modport slave (
    input  o_pixel_data,
    input  o_pixel_valid,
    input  o_pixel_index,
    output i_pixel_ready
  );
endinterface

// File: rtl/ws_frame_sequencer.sv
// Single-wire LED frame sequencer: classifies high pulses into bits, assembles 24-bit
// pixels MSB first, detects the low latch gap and presents pixels over valid/ready.
module ws_frame_sequencer #(
  parameter int WIDTH     = 10,
  parameter int T0H_MIN   = 10,
  parameter int T1H_MIN   = 35,
  parameter int TH_MAX    = 90,
  parameter int RESET_MIN = 500,
  parameter int IDX_W     = 9
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rise,
  input  logic                  i_fall,
  input  logic [WIDTH-1:0]      i_timer_value,
  ws_frame_sequencer_if.master  pix,
  output logic                  o_latch,
  output logic                  o_err_glitch,
  output logic                  o_err_partial,
  output logic                  o_err_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] L_T0H_MIN   = WIDTH'(T0H_MIN);
  localparam logic [WIDTH-1:0] L_T1H_MIN   = WIDTH'(T1H_MIN);
  localparam logic [WIDTH-1:0] L_TH_MAX    = WIDTH'(TH_MAX);
  localparam logic [WIDTH-1:0] L_RESET_MIN = WIDTH'(RESET_MIN);
  localparam logic [IDX_W-1:0] L_IDX_MAX   = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] L_IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nx;
  logic [22:0]      r_shift;
  logic [22:0]      w_shift_nx;
  logic [4:0]       r_count;
  logic [4:0]       w_count_nx;
  logic             r_err_high;
  logic             w_err_high_nx;
  logic [23:0]      r_data;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_idx_clr_pend;
  logic             r_latch;
  logic             r_glitch;
  logic             r_partial;
  logic             r_overflow;

  logic             w_both;
  logic             w_gap;
  logic             w_legal;
  logic             w_is_one;
  logic [23:0]      w_word;
  logic             w_latch;
  logic             w_glitch;
  logic             w_partial;
  logic             w_word_done;
  logic             w_accept;
  logic             w_blocked;

  assign w_both    = i_rise & i_fall;
  assign w_gap     = (i_timer_value >= L_RESET_MIN);
  assign w_legal   = (i_timer_value >= L_T0H_MIN) && (i_timer_value <= L_TH_MAX);
  assign w_is_one  = (i_timer_value >= L_T1H_MIN);
  assign w_word    = {r_shift, w_is_one};
  assign w_accept  = r_valid & pix.i_pixel_ready;
  assign w_blocked = r_valid & ~pix.i_pixel_ready;

  // Line-state tracking, bit classification and frame-gap detection
  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_count_nx    = r_count;
    w_err_high_nx = r_err_high;
    w_latch       = 1'b0;
    w_glitch      = 1'b0;
    w_partial     = 1'b0;
    w_word_done   = 1'b0;
    if (w_both && (r_state != S_IDLE)) begin
      w_glitch      = 1'b1;
      w_state_nx    = S_ERROR;
      w_shift_nx    = 23'd0;
      w_count_nx    = 5'd0;
      w_err_high_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_rise) begin
            w_state_nx = S_HIGH;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_HIGH: begin
          if (i_fall && w_legal) begin
            w_state_nx = S_LOW;
            if (r_count == 5'd23) begin
              w_word_done = 1'b1;
              w_count_nx  = 5'd0;
              w_shift_nx  = 23'd0;
            end else begin
              w_count_nx  = r_count + 5'd1;
              w_shift_nx  = w_word[22:0];
            end
          end else if (i_fall) begin
            w_glitch      = 1'b1;
            w_state_nx    = S_ERROR;
            w_shift_nx    = 23'd0;
            w_count_nx    = 5'd0;
            w_err_high_nx = 1'b0;
          end else begin
            w_state_nx = S_HIGH;
          end
        end
        S_LOW: begin
          if (i_rise) begin
            w_state_nx = S_HIGH;
          end else if (!i_fall && w_gap) begin
            w_latch    = 1'b1;
            w_partial  = (r_count != 5'd0);
            w_shift_nx = 23'd0;
            w_count_nx = 5'd0;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_LOW;
          end
        end
        S_ERROR: begin
          // Only a genuine low gap (not a long high) may end the error state
          if (i_rise) begin
            w_err_high_nx = 1'b1;
          end else if (i_fall) begin
            w_err_high_nx = 1'b0;
          end else if (!r_err_high && w_gap) begin
            w_latch    = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_ERROR;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Control state and registered pulse outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 23'd0;
      r_count    <= 5'd0;
      r_err_high <= 1'b0;
      r_latch    <= 1'b0;
      r_glitch   <= 1'b0;
      r_partial  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_count    <= w_count_nx;
      r_err_high <= w_err_high_nx;
      r_latch    <= w_latch;
      r_glitch   <= w_glitch;
      r_partial  <= w_partial;
      r_overflow <= w_word_done & w_blocked;
    end
  end

  // Pixel holding register, handshake and frame index
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data         <= 24'd0;
      r_valid        <= 1'b0;
      r_idx          <= {IDX_W{1'b0}};
      r_idx_clr_pend <= 1'b0;
    end else begin
      if (w_word_done && !w_blocked) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      // A latch while a pixel is still held defers the index clear to its acceptance
      if (w_latch && w_blocked) begin
        r_idx_clr_pend <= 1'b1;
      end else if (w_latch) begin
        r_idx          <= {IDX_W{1'b0}};
        r_idx_clr_pend <= 1'b0;
      end else if (w_accept && r_idx_clr_pend) begin
        r_idx          <= {IDX_W{1'b0}};
        r_idx_clr_pend <= 1'b0;
      end else if (w_accept && (r_idx != L_IDX_MAX)) begin
        r_idx          <= r_idx + L_IDX_ONE;
      end else begin
        r_idx          <= r_idx;
      end
    end
  end

  assign pix.o_pixel_data  = r_data;
  assign pix.o_pixel_valid = r_valid;
  assign pix.o_pixel_index = r_idx;
  assign o_latch           = r_latch;
  assign o_err_glitch      = r_glitch;
  assign o_err_partial     = r_partial;
  assign o_err_overflow    = r_overflow;

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Self-checking bench: emulates the edge detector/timer from a line waveform and compares
// the sequencer against a pulse-list decoding model.
module tb_ws_frame_sequencer;
  localparam int WIDTH = 10;
  localparam int RMIN  = 500;
  localparam int IDX_W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rise = 1'b0, fall = 1'b0;
  logic [WIDTH-1:0] tv = '0;
  logic latch, glitch, partial, ovf;

  ws_frame_sequencer_if #(.IDX_W(IDX_W)) pix();

  ws_frame_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_rise(rise), .i_fall(fall), .i_timer_value(tv),
    .pix(pix), .o_latch(latch), .o_err_glitch(glitch), .o_err_partial(partial),
    .o_err_overflow(ovf)
  );

  int n_checks = 0, n_err = 0;
  bit line = 1'b0;
  int tcnt = 1023;
  int cyc = 0, latch_cyc = -1, gap_cyc = -2, partial_cyc = -3;
  int n_latch = 0, n_glitch = 0, n_partial = 0, n_ovf = 0;
  bit ready_lvl = 1'b1, ready_rand = 1'b0;
  logic [23:0] acc_data[$];
  int          acc_idx[$];
  logic [23:0] exp_data[$];
  int          exp_idx[$];

  task automatic clear_obs();
    n_latch = 0; n_glitch = 0; n_partial = 0; n_ovf = 0;
    acc_data.delete(); acc_idx.delete(); exp_data.delete(); exp_idx.delete();
  endtask

  // One clock: drive at negedge, record transfers, sample outputs #1 after posedge
  task automatic step(input bit r, input bit f, input logic [WIDTH-1:0] t, input bit rs);
    @(negedge clk);
    rise = r; fall = f; tv = t; rst = rs;
    pix.i_pixel_ready = ready_rand ? ($urandom_range(3, 0) != 0) : ready_lvl;
    if (pix.o_pixel_valid && pix.i_pixel_ready && !rs) begin
      acc_data.push_back(pix.o_pixel_data);
      acc_idx.push_back(int'(pix.o_pixel_index));
    end
    if (!r && !f && !line && (t == WIDTH'(RMIN))) gap_cyc = cyc;
    @(posedge clk);
    #1;
    if (latch)   begin n_latch++;   latch_cyc = cyc;   end
    if (partial) begin n_partial++; partial_cyc = cyc; end
    if (glitch)  n_glitch++;
    if (ovf)     n_ovf++;
    cyc++;
  endtask

  // Hold the line at lvl for n cycles; timer shows cycles since the last edge
  task automatic seg(input bit lvl, input int n);
    for (int k = 0; k < n; k++) begin
      bit r, f;
      r = (k == 0) && lvl && !line;
      f = (k == 0) && !lvl && line;
      step(r, f, WIDTH'(tcnt), 1'b0);
      if (r || f) begin
        tcnt = 1;
        line = lvl;
      end else if (tcnt < 1023) begin
        tcnt++;
      end
    end
  endtask

  task automatic pulse(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
  endtask

  function automatic int rand_high(input bit b);
    return b ? int'($urandom_range(90, 35)) : int'($urandom_range(34, 10));
  endfunction

  task automatic send_word(input logic [23:0] w, input bit expect_it, input int idx);
    for (int i = 23; i >= 0; i--) pulse(rand_high(w[i]), int'($urandom_range(60, 20)));
    if (expect_it) begin
      exp_data.push_back(w);
      exp_idx.push_back(idx);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    n_checks++; if (pix.o_pixel_data !== 24'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", pix.o_pixel_data); end
    n_checks++; if (pix.o_pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pix.o_pixel_valid); end
    n_checks++; if (pix.o_pixel_index !== 9'd0) begin n_err++; $display("FAIL reset_index: got %0d want 0", pix.o_pixel_index); end
    n_checks++; if ({latch, glitch, partial, ovf} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {latch, glitch, partial, ovf}); end
    step(1'b0, 1'b0, '0, 1'b0);
    line = 1'b0; tcnt = 1023;
  endtask

  task automatic test_all_ones();
    clear_obs(); ready_lvl = 1'b1;
    for (int i = 0; i < 23; i++) pulse(40, 40);
    seg(1'b1, 40);
    seg(1'b0, 1);
    n_checks++; if (pix.o_pixel_valid !== 1'b1 || pix.o_pixel_data !== 24'hFFFFFF) begin n_err++; $display("FAIL ones_pixel: got v=%b d=%h want v=1 d=ffffff", pix.o_pixel_valid, pix.o_pixel_data); end
    seg(1'b0, 1);
    n_checks++; if (pix.o_pixel_valid !== 1'b0 || pix.o_pixel_index !== 9'd1) begin n_err++; $display("FAIL ones_accept: got v=%b idx=%0d want v=0 idx=1", pix.o_pixel_valid, pix.o_pixel_index); end
    seg(1'b0, 598);
    n_checks++; if (n_latch !== 1 || latch_cyc !== gap_cyc) begin n_err++; $display("FAIL ones_latch: got n=%0d at %0d want 1 at %0d", n_latch, latch_cyc, gap_cyc); end
    n_checks++; if (pix.o_pixel_index !== 9'd0) begin n_err++; $display("FAIL ones_next_index: got %0d want 0", pix.o_pixel_index); end
    n_checks++; if (acc_data.size() !== 1 || n_glitch !== 0 || n_partial !== 0) begin n_err++; $display("FAIL ones_counts: got acc=%0d g=%0d p=%0d want 1 0 0", acc_data.size(), n_glitch, n_partial); end
  endtask

  task automatic test_pattern();
    logic [23:0] w;
    w = 24'hA53C0F;
    clear_obs(); ready_lvl = 1'b1;
    for (int i = 23; i >= 1; i--) pulse(w[i] ? 40 : 15, 40);
    seg(1'b1, w[0] ? 40 : 15);
    seg(1'b0, 1);
    n_checks++; if (pix.o_pixel_valid !== 1'b1 || pix.o_pixel_data !== 24'hA53C0F || pix.o_pixel_index !== 9'd0) begin n_err++; $display("FAIL pattern_pixel: got v=%b d=%h idx=%0d want 1 a53c0f 0", pix.o_pixel_valid, pix.o_pixel_data, pix.o_pixel_index); end
    seg(1'b0, 1);
    n_checks++; if (pix.o_pixel_index !== 9'd1) begin n_err++; $display("FAIL pattern_index: got %0d want 1", pix.o_pixel_index); end
    seg(1'b0, 600);
    n_checks++; if (n_latch !== 1 || pix.o_pixel_index !== 9'd0) begin n_err++; $display("FAIL pattern_latch: got n=%0d idx=%0d want 1 0", n_latch, pix.o_pixel_index); end
  endtask

  task automatic test_glitch();
    int hs[4] = '{5, 95, 9, 91};
    ready_lvl = 1'b1;
    foreach (hs[i]) begin
      clear_obs();
      seg(1'b1, hs[i]);
      seg(1'b0, 20);
      n_checks++; if (n_glitch !== 1) begin n_err++; $display("FAIL glitch_%0d: got %0d pulses want 1", hs[i], n_glitch); end
      pulse(40, 20);
      n_checks++; if (n_latch !== 0 || n_glitch !== 1) begin n_err++; $display("FAIL glitch_hold_%0d: got latch=%0d g=%0d want 0 1", hs[i], n_latch, n_glitch); end
      seg(1'b0, 600);
      n_checks++; if (n_latch !== 1 || acc_data.size() !== 0 || pix.o_pixel_valid !== 1'b0) begin n_err++; $display("FAIL glitch_recover_%0d: got latch=%0d acc=%0d want 1 0", hs[i], n_latch, acc_data.size()); end
    end
  endtask

  task automatic test_boundary();
    int hs[4] = '{10, 34, 35, 90};
    clear_obs(); ready_lvl = 1'b1;
    for (int i = 0; i < 24; i++) pulse(hs[i % 4], 20);
    seg(1'b0, 600);
    n_checks++; if (acc_data.size() !== 1 || n_glitch !== 0) begin n_err++; $display("FAIL bound_count: got acc=%0d g=%0d want 1 0", acc_data.size(), n_glitch); end
    else begin
      n_checks++; if (acc_data[0] !== 24'h333333 || acc_idx[0] !== 0) begin n_err++; $display("FAIL bound_data: got %h idx %0d want 333333 idx 0", acc_data[0], acc_idx[0]); end
    end
  endtask

  task automatic test_partial();
    clear_obs(); ready_lvl = 1'b1;
    for (int i = 0; i < 12; i++) pulse(rand_high(1'($urandom)), 30);
    seg(1'b0, 600);
    n_checks++; if (n_partial !== 1 || n_latch !== 1 || partial_cyc !== latch_cyc) begin n_err++; $display("FAIL partial_pulse: got p=%0d l=%0d cyc %0d/%0d want 1 1 same", n_partial, n_latch, partial_cyc, latch_cyc); end
    send_word(24'($urandom), 1'b1, 0);
    seg(1'b0, 600);
    n_checks++; if (acc_data.size() !== 1 || n_partial !== 1) begin n_err++; $display("FAIL partial_next: got acc=%0d p=%0d want 1 1", acc_data.size(), n_partial); end
    else begin
      n_checks++; if (acc_data[0] !== exp_data[0] || acc_idx[0] !== 0) begin n_err++; $display("FAIL partial_data: got %h idx %0d want %h idx 0", acc_data[0], acc_idx[0], exp_data[0]); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] wa, wb;
    wa = 24'($urandom); wb = ~wa;
    clear_obs(); ready_lvl = 1'b0;
    send_word(wa, 1'b0, 0);
    n_checks++; if (pix.o_pixel_valid !== 1'b1 || pix.o_pixel_data !== wa) begin n_err++; $display("FAIL ovf_first: got v=%b d=%h want 1 %h", pix.o_pixel_valid, pix.o_pixel_data, wa); end
    send_word(wb, 1'b0, 0);
    n_checks++; if (n_ovf !== 1 || pix.o_pixel_data !== wa || pix.o_pixel_valid !== 1'b1 || pix.o_pixel_index !== 9'd0) begin n_err++; $display("FAIL ovf_drop: got n=%0d d=%h idx=%0d want 1 %h 0", n_ovf, pix.o_pixel_data, pix.o_pixel_index, wa); end
    ready_lvl = 1'b1;
    seg(1'b0, 2);
    n_checks++; if (acc_data.size() !== 1 || pix.o_pixel_valid !== 1'b0 || pix.o_pixel_index !== 9'd1) begin n_err++; $display("FAIL ovf_release: got acc=%0d v=%b idx=%0d want 1 0 1", acc_data.size(), pix.o_pixel_valid, pix.o_pixel_index); end
    else begin
      n_checks++; if (acc_data[0] !== wa) begin n_err++; $display("FAIL ovf_data: got %h want %h", acc_data[0], wa); end
    end
    seg(1'b0, 600);
  endtask

  task automatic test_both_edges();
    clear_obs(); ready_lvl = 1'b1;
    for (int i = 0; i < 5; i++) pulse(rand_high(1'($urandom)), 30);
    step(1'b1, 1'b1, WIDTH'(tcnt), 1'b0);
    tcnt = 1;
    seg(1'b0, 2);
    n_checks++; if (n_glitch !== 1) begin n_err++; $display("FAIL both_edges: got %0d glitch want 1", n_glitch); end
    seg(1'b0, 600);
    n_checks++; if (n_latch !== 1 || acc_data.size() !== 0) begin n_err++; $display("FAIL both_recover: got latch=%0d acc=%0d want 1 0", n_latch, acc_data.size()); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] wb;
    clear_obs(); ready_lvl = 1'b0;
    send_word(24'($urandom), 1'b0, 0);
    for (int i = 0; i < 10; i++) pulse(rand_high(1'($urandom)), 30);
    seg(1'b1, 20);
    step(1'b1, 1'b0, WIDTH'(tcnt), 1'b1);
    n_checks++; if (pix.o_pixel_valid !== 1'b0 || pix.o_pixel_data !== 24'd0 || pix.o_pixel_index !== 9'd0 || {latch, glitch, partial, ovf} !== 4'b0000) begin n_err++; $display("FAIL midreset_outputs: got v=%b d=%h idx=%0d p=%b want all 0", pix.o_pixel_valid, pix.o_pixel_data, pix.o_pixel_index, {latch, glitch, partial, ovf}); end
    step(1'b1, 1'b0, WIDTH'(tcnt), 1'b1);
    step(1'b1, 1'b0, WIDTH'(tcnt), 1'b1);
    line = 1'b0; tcnt = 1023; ready_lvl = 1'b1;
    wb = 24'($urandom);
    clear_obs();
    send_word(wb, 1'b1, 0);
    seg(1'b0, 600);
    n_checks++; if (acc_data.size() !== 1 || n_ovf !== 0 || n_glitch !== 0) begin n_err++; $display("FAIL midreset_next: got acc=%0d o=%0d g=%0d want 1 0 0", acc_data.size(), n_ovf, n_glitch); end
    else begin
      n_checks++; if (acc_data[0] !== wb || acc_idx[0] !== 0) begin n_err++; $display("FAIL midreset_data: got %h idx %0d want %h idx 0", acc_data[0], acc_idx[0], wb); end
    end
  endtask

  task automatic test_random_frames();
    int nw;
    clear_obs(); ready_rand = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      nw = int'($urandom_range(3, 1));
      for (int j = 0; j < nw; j++) send_word(24'($urandom), 1'b1, j);
      seg(1'b0, 600);
    end
    ready_rand = 1'b0;
    n_checks++; if (acc_data.size() !== exp_data.size() || n_latch !== 3 || n_ovf !== 0) begin n_err++; $display("FAIL rand_count: got acc=%0d latch=%0d ovf=%0d want %0d 3 0", acc_data.size(), n_latch, n_ovf, exp_data.size()); end
    else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_checks++; if (acc_data[i] !== exp_data[i] || acc_idx[i] !== exp_idx[i]) begin n_err++; $display("FAIL rand_pixel_%0d: got %h idx %0d want %h idx %0d", i, acc_data[i], acc_idx[i], exp_data[i], exp_idx[i]); end
      end
    end
  endtask

  initial begin
    pix.i_pixel_ready = 1'b1;
    test_reset();
    test_all_ones();
    test_pattern();
    test_glitch();
    test_boundary();
    test_partial();
    test_overflow();
    test_both_edges();
    test_reset_mid();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
